// File: rtl/sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_access_ctrl
//
// Purpose:
//   Turns the core's single-word req/ready memory handshake into properly
//   sequenced cycles on an external asynchronous SRAM. The controller owns
//   strobe timing and data-bus turnaround, so the core never has to know
//   about OE/WE spacing or who is driving the bus.
//
// Ports:
//   Clk, Reset          clock (rising edge) and asynchronous active-high reset
//   req, wr_en          access request and direction (1 = write); sampled in IDLE only
//   addr, wdata         word address and write data; sampled with req
//   rdata               read data, held until the next read capture
//   ready               one-cycle completion pulse
//   busy                high from the cycle after accept through the ready cycle
//   CE, UB, LB, OE, WE  active-low SRAM strobes, all registered
//   ADDR                registered SRAM address
//   Data                bidirectional SRAM data bus, driven only while writing
// ---------------------------------------------------------------------------
module sram_access_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Data
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACT,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Registered strobe/status outputs. Each is decoded from the next state so
  // that the flop output lines up exactly with the state it belongs to.
  logic ce_n_q, ce_n_d;
  logic bl_n_q, bl_n_d;     // shared by UB and LB: only full-word accesses exist
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic drive_q, drive_d;   // data bus output enable
  logic ready_q, ready_d;
  logic busy_q, busy_d;

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = addr;
          wbuf_d = wdata;
          // Counter holds "remaining active cycles minus one"; the setup
          // cycle of a write does not consume it.
          if (wr_en) begin
            state_d = ST_WR_SETUP;
            cnt_d   = CNT_W'(WR_WAIT - 1);
          end else begin
            state_d = ST_RD_ACT;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end

      ST_RD_ACT: begin
        if (cnt_q == '0) begin
          // Last OE-low cycle: the SRAM output has had RD_WAIT cycles to settle.
          rdata_d = Data;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
      end

      ST_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WR_HOLD: begin
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // Always return to IDLE so every access is separated by an idle bus.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state (feeds the output registers)
  // -------------------------------------------------------------------------
  always_comb begin
    ce_n_d  = 1'b1;
    bl_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    drive_d = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b1;

    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end

      ST_RD_ACT: begin
        ce_n_d = 1'b0;
        bl_n_d = 1'b0;
        oe_n_d = 1'b0;
      end

      ST_WR_SETUP, ST_WR_HOLD: begin
        // Data is valid before WE falls and stays valid after WE rises.
        ce_n_d  = 1'b0;
        bl_n_d  = 1'b0;
        drive_d = 1'b1;
      end

      ST_WR_PULSE: begin
        ce_n_d  = 1'b0;
        bl_n_d  = 1'b0;
        we_n_d  = 1'b0;
        drive_d = 1'b1;
      end

      ST_DONE: begin
        ready_d = 1'b1;
      end

      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      bl_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      bl_n_q  <= bl_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drive_q <= drive_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign CE    = ce_n_q;
  assign UB    = bl_n_q;
  assign LB    = bl_n_q;
  assign OE    = oe_n_q;
  assign WE    = we_n_q;
  assign ADDR  = addr_q;
  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;

  // Drive enable only exists in write states, where OE is held high.
  assign Data = drive_q ? wbuf_q : {DATA_W{1'bz}};

endmodule
